// File: rtl/out_sched_pkg.sv
// ============================================================================
// out_sched_pkg - drain-state type, width constants and lane-select helper
//                 shared by out_fifo_sched and rr_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package out_sched_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } drain_state_e;

    localparam int DefBufferWidth = 4;
    localparam int CountWidth     = DefBufferWidth + 1;
    localparam int MaxReq         = 8;

    // Index of the set bit in a one-hot lane vector; 0 when no bit is set.
    function automatic logic [2:0] lane_select(input logic [MaxReq-1:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MaxReq; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter - one-hot push-port arbiter for the result lanes.
//              OUT_SCHED_RR_EN selects round-robin; otherwise fixed priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import out_sched_pkg::*;
#(
    parameter int NumReq = 4
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic [NumReq-1:0] req,
    input  logic              advance,
    output logic [NumReq-1:0] grant
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

`ifdef OUT_SCHED_RR_EN
    logic [PtrW-1:0] rr_ptr;
    logic [PtrW-1:0] idx;
    logic            found;

    // Search begins at rr_ptr and wraps; first requesting lane wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = PtrW'((int'(rr_ptr) + k) % NumReq);
            if (advance && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= PtrW'((int'(lane_select(MaxReq'(grant))) + 1) % NumReq);
        end
    end
`else
    logic found;
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ aclr;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            if (advance && !found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/out_fifo_sched.sv
// ============================================================================
// out_fifo_sched - push arbitration, occupancy tracking and drain stage for
//                  the engine output FIFO. Macro: OUT_SCHED_RR_EN (round-robin).
// Revision: 1.0
// ============================================================================
`default_nettype none

module out_fifo_sched
    import out_sched_pkg::*;
#(
    parameter int DataWidth   = 32,
    parameter int NumReq      = 4,
    parameter int BufferSize  = 16,
    parameter int BufferWidth = DefBufferWidth
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic [NumReq-1:0]           Req,
    input  logic [NumReq*DataWidth-1:0] ReqData,
    output logic [NumReq-1:0]           Grant,
    output logic                        FifoPush,
    output logic [DataWidth-1:0]        FifoDataIn,
    output logic                        FifoPop,
    input  logic [DataWidth-1:0]        FifoDataOut,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [DataWidth-1:0]        OutData,
    output logic [BufferWidth:0]        Count
);

    localparam int CntW = BufferWidth + 1;

    logic [CntW-1:0]      count_q;
    logic                 can_push;
    logic                 load;
    drain_state_e         state;
    drain_state_e         state_nxt;
    logic [DataWidth-1:0] out_data_q;

    // Full is judged on Count alone, so a pop never frees a slot in the same cycle.
    assign can_push = (count_q < CntW'(BufferSize));

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .clk     (clk),
        .aclr    (aclr),
        .req     (Req),
        .advance (can_push),
        .grant   (Grant)
    );

    assign FifoPush = |Grant;

    always_comb begin
        FifoDataIn = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (Grant[i]) begin
                FifoDataIn = FifoDataIn | ReqData[i*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            count_q <= '0;
        end else if (FifoPush && !load) begin
            count_q <= count_q + CntW'(1);
        end else if (!FifoPush && load) begin
            count_q <= count_q - CntW'(1);
        end
    end

    // A fresh word is fetched whenever the output slot is free or being consumed.
    assign load = (count_q != '0) && ((state == EMPTY) || OutReady);

    always_comb begin
        state_nxt = state;
        FifoPop   = load;
        case (state)
            EMPTY: begin
                if (load) begin
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (load) begin
                    state_nxt = HELD;
                end else if (OutReady) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state      <= EMPTY;
            out_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_data_q <= FifoDataOut;
            end
        end
    end

    assign OutValid = (state == HELD);
    assign OutData  = out_data_q;
    assign Count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_out_fifo_sched.sv
// Bench for out_fifo_sched: attached FIFO model plus a queue-based reference
// model of occupancy, lane arbitration and the drained word stream.
`default_nettype none
`timescale 1ns/1ps

module tb_out_fifo_sched;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int BS = 16;
    localparam int BW = 4;

    logic            clk      = 1'b0;
    logic            aclr     = 1'b0;
    logic [NR-1:0]   lane_req = '0;
    logic [DW-1:0]   lane_data [NR];
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   Grant;
    logic            FifoPush;
    logic [DW-1:0]   FifoDataIn;
    logic            FifoPop;
    logic [DW-1:0]   FifoDataOut;
    logic            OutValid;
    logic            OutReady = 1'b0;
    logic [DW-1:0]   OutData;
    logic [BW:0]     Count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = lane_data[i];
        end
    end

    out_fifo_sched #(
        .DataWidth   (DW),
        .NumReq      (NR),
        .BufferSize  (BS),
        .BufferWidth (BW)
    ) dut (
        .clk         (clk),
        .aclr        (aclr),
        .Req         (lane_req),
        .ReqData     (req_data),
        .Grant       (Grant),
        .FifoPush    (FifoPush),
        .FifoDataIn  (FifoDataIn),
        .FifoPop     (FifoPop),
        .FifoDataOut (FifoDataOut),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutData     (OutData),
        .Count       (Count)
    );

    // Attached 16-entry FIFO with combinational read port.
    logic [DW-1:0] fmem [BS];
    int frd, fwr;
    always @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            frd <= 0;
            fwr <= 0;
        end else begin
            if (FifoPush) begin
                fmem[fwr] <= FifoDataIn;
                fwr       <= (fwr + 1) % BS;
            end
            if (FifoPop) begin
                frd <= (frd + 1) % BS;
            end
        end
    end
    assign FifoDataOut = fmem[frd];

    // Reference model: m_q holds words inside the FIFO, m_data/m_valid the output slot.
    logic [DW-1:0] m_q [$];
    int            m_rr    = 0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic [NR-1:0] m_grant = '0;
    logic [DW-1:0] got    [$];
    logic [DW-1:0] pushed [$];

    function automatic logic [NR-1:0] model_grant();
        logic [NR-1:0] g;
        g = '0;
        if (m_q.size() < BS) begin
            for (int k = 0; k < NR; k++) begin
                int l;
                l = (m_rr + k) % NR;
                if (g == '0 && lane_req[l]) g[l] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic bit model_pop();
        return (m_q.size() != 0) && (!m_valid || OutReady);
    endfunction

    task automatic model_step();
        logic [NR-1:0] g;
        bit ld;
        g  = model_grant();
        ld = model_pop();
        if (ld) begin
            m_data  = m_q.pop_front();
            m_valid = 1'b1;
        end else if (m_valid && OutReady) begin
            m_valid = 1'b0;
        end
        for (int l = 0; l < NR; l++) begin
            if (g[l]) begin
                m_q.push_back(lane_data[l]);
`ifdef OUT_SCHED_RR_EN
                m_rr = (l + 1) % NR;
`endif
            end
        end
        m_grant = g;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rr    = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_grant = '0;
    endtask

    task automatic lanes_after_edge();
        for (int l = 0; l < NR; l++) begin
            if (m_grant[l]) lane_req[l] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        aclr     = 1'b0;
        lane_req = '0;
        OutReady = 1'b0;
        model_reset();
        @(negedge clk);
        aclr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        aclr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (Count !== 5'd0) begin
            n_err++; $display("FAIL reset_count: got %0d expected 0", Count);
        end
        n_cmp++;
        if (OutValid !== 1'b0 || OutData !== '0) begin
            n_err++; $display("FAIL reset_out: got valid=%b data=%h expected 0/0", OutValid, OutData);
        end
        n_cmp++;
        if (Grant !== '0 || FifoPush !== 1'b0 || FifoPop !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl: got grant=%b push=%b pop=%b expected all 0", Grant, FifoPush, FifoPop);
        end
        aclr = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        apply_reset();
        lane_data[0] = 32'h0000_00A5;
        lane_req     = 4'b0001;
        OutReady     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (Grant !== ((c == 0) ? 4'b0001 : 4'b0000)) begin
                n_err++; $display("FAIL single_grant c%0d: got %b", c, Grant);
            end
            n_cmp++;
            if (Count !== 5'(m_q.size())) begin
                n_err++; $display("FAIL single_count c%0d: got %0d expected %0d", c, Count, m_q.size());
            end
            if (c == 2) begin
                n_cmp++;
                if (OutValid !== 1'b1 || OutData !== 32'h0000_00A5) begin
                    n_err++; $display("FAIL single_out: got valid=%b data=%h expected 1/000000a5", OutValid, OutData);
                end
            end
            model_step();
            @(posedge clk);
            #1;
            lanes_after_edge();
        end
        @(negedge clk);
        n_cmp++;
        if (Count !== 5'd0 || OutValid !== 1'b0) begin
            n_err++; $display("FAIL single_drained: got count=%0d valid=%b expected 0/0", Count, OutValid);
        end
    endtask

    task automatic test_fairness();
        logic [NR-1:0] exp_g;
        apply_reset();
        OutReady = 1'b1;
        for (int l = 0; l < NR; l++) lane_data[l] = $urandom;
        lane_req = '1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
`ifdef OUT_SCHED_RR_EN
            exp_g = 4'(1 << (c % NR));
`else
            exp_g = 4'b0001;
`endif
            n_cmp++;
            if (Grant !== exp_g) begin
                n_err++; $display("FAIL fair_grant c%0d: got %b expected %b", c, Grant, exp_g);
            end
            n_cmp++;
            if (OutValid !== m_valid || (m_valid && OutData !== m_data)) begin
                n_err++; $display("FAIL fair_out c%0d: got %b/%h expected %b/%h", c, OutValid, OutData, m_valid, m_data);
            end
            model_step();
            @(posedge clk);
            #1;
            lanes_after_edge();
            for (int l = 0; l < NR; l++) begin
                if (!lane_req[l]) begin
                    lane_data[l] = $urandom;
                    lane_req[l]  = 1'b1;
                end
            end
        end
    endtask

    task automatic test_full();
        int  grants;
        int  seq;
        bit  done;
        apply_reset();
        OutReady     = 1'b0;
        seq          = 0;
        grants       = 0;
        done         = 1'b0;
        lane_data[0] = 32'h100;
        lane_req     = 4'b0001;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            n_cmp++;
            if (Grant !== model_grant() || Count !== 5'(m_q.size())) begin
                n_err++; $display("FAIL full_fill c%0d: got grant=%b count=%0d expected %b/%0d", c, Grant, Count, model_grant(), m_q.size());
            end
            if (Grant == '0) begin
                done = 1'b1;
            end else begin
                grants++;
                model_step();
                @(posedge clk);
                #1;
                lanes_after_edge();
                if (!lane_req[0]) begin
                    seq++;
                    lane_data[0] = 32'h100 + seq;
                    lane_req[0]  = 1'b1;
                end
            end
        end
        n_cmp++;
        if (grants != 17 || Count !== 5'd16) begin
            n_err++; $display("FAIL full_level: got grants=%0d count=%0d expected 17/16", grants, Count);
        end
        n_cmp++;
        if (OutValid !== 1'b1 || OutData !== 32'h100) begin
            n_err++; $display("FAIL full_head: got %b/%h expected 1/00000100", OutValid, OutData);
        end
        OutReady = 1'b1;
        #1;
        n_cmp++;
        if (FifoPop !== 1'b1 || Grant !== 4'b0000) begin
            n_err++; $display("FAIL full_pop_no_push: got pop=%b grant=%b expected 1/0000", FifoPop, Grant);
        end
        for (int c = 0; c < 20; c++) begin
            model_step();
            @(posedge clk);
            #1;
            lanes_after_edge();
            if (!lane_req[0]) begin
                seq++;
                lane_data[0] = 32'h100 + seq;
                lane_req[0]  = 1'b1;
            end
            @(negedge clk);
            if (c == 0) begin
                n_cmp++;
                if (Count !== 5'd15 || Grant !== 4'b0001 || FifoPop !== 1'b1 || OutData !== 32'h101) begin
                    n_err++; $display("FAIL full_resume: got count=%0d grant=%b pop=%b data=%h expected 15/0001/1/00000101",
                                      Count, Grant, FifoPop, OutData);
                end
            end
            n_cmp++;
            if (Count !== 5'(m_q.size()) || OutData !== m_data || Grant !== model_grant()) begin
                n_err++; $display("FAIL full_stream c%0d: got count=%0d data=%h expected %0d/%h", c, Count, OutData, m_q.size(), m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        int            nxt;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        apply_reset();
        got.delete();
        nxt          = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        lane_data[2] = 32'd0;
        lane_req     = 4'b0100;
        OutReady     = 1'b0;
        for (int c = 0; c < 100 && got.size() < 10; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if (OutValid !== 1'b1 || OutData !== prev_data) begin
                    n_err++; $display("FAIL bp_hold c%0d: got %b/%h expected 1/%h", c, OutValid, OutData, prev_data);
                end
            end
            n_cmp++;
            if (OutValid !== m_valid || (m_valid && OutData !== m_data)) begin
                n_err++; $display("FAIL bp_model c%0d: got %b/%h expected %b/%h", c, OutValid, OutData, m_valid, m_data);
            end
            if (OutValid && OutReady) got.push_back(OutData);
            prev_stall = OutValid && !OutReady;
            prev_data  = OutData;
            model_step();
            @(posedge clk);
            #1;
            lanes_after_edge();
            if (m_grant[2]) begin
                nxt++;
                if (nxt < 10) begin
                    lane_data[2] = DW'(nxt);
                    lane_req[2]  = 1'b1;
                end
            end
            OutReady = ~OutReady;
        end
        n_cmp++;
        if (got.size() != 10) begin
            n_err++; $display("FAIL bp_count: got %0d words expected 10", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== DW'(i)) begin
                n_err++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], DW'(i));
            end
        end
    endtask

    task automatic test_wrap();
        int issued;
        apply_reset();
        got.delete();
        pushed.delete();
        issued = 0;
        for (int c = 0; c < 600 && got.size() < 40; c++) begin
            for (int l = 0; l < NR; l++) begin
                if (!lane_req[l] && issued < 40 && $urandom_range(0, 3) != 0) begin
                    lane_data[l] = {8'(l), 24'(issued)};
                    lane_req[l]  = 1'b1;
                    issued++;
                end
            end
            OutReady = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            n_cmp++;
            if (Grant !== model_grant() || FifoPop !== model_pop()) begin
                n_err++; $display("FAIL wrap_ctl c%0d: got grant=%b pop=%b expected %b/%b", c, Grant, FifoPop, model_grant(), model_pop());
            end
            n_cmp++;
            if (Count !== 5'(m_q.size()) || Count > 5'd16) begin
                n_err++; $display("FAIL wrap_count c%0d: got %0d expected %0d", c, Count, m_q.size());
            end
            n_cmp++;
            if (OutValid !== m_valid || (m_valid && OutData !== m_data)) begin
                n_err++; $display("FAIL wrap_out c%0d: got %b/%h expected %b/%h", c, OutValid, OutData, m_valid, m_data);
            end
            if (OutValid && OutReady) got.push_back(OutData);
            for (int l = 0; l < NR; l++) begin
                if (model_grant() == 4'(1 << l)) pushed.push_back(lane_data[l]);
            end
            model_step();
            @(posedge clk);
            #1;
            lanes_after_edge();
        end
        n_cmp++;
        if (got.size() != 40 || pushed.size() != 40) begin
            n_err++; $display("FAIL wrap_total: got out=%0d pushed=%0d expected 40/40", got.size(), pushed.size());
        end
        for (int i = 0; i < got.size() && i < pushed.size(); i++) begin
            n_cmp++;
            if (got[i] !== pushed[i]) begin
                n_err++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, got[i], pushed[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int seq;
        apply_reset();
        OutReady     = 1'b0;
        seq          = 0;
        lane_data[0] = 32'h200;
        lane_req     = 4'b0001;
        for (int c = 0; c < 40 && !(m_q.size() == 5 && m_valid); c++) begin
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
            lanes_after_edge();
            if (!lane_req[0]) begin
                seq++;
                lane_data[0] = 32'h200 + seq;
                lane_req[0]  = 1'b1;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (Count !== 5'd5 || OutValid !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: got count=%0d valid=%b expected 5/1", Count, OutValid);
        end
        #2;
        lane_req = '0;
        aclr     = 1'b0;
        #1;
        n_cmp++;
        if (Count !== 5'd0 || OutValid !== 1'b0 || Grant !== '0 || OutData !== '0) begin
            n_err++; $display("FAIL midrst_async: got count=%0d valid=%b grant=%b data=%h expected 0/0/0000/0",
                              Count, OutValid, Grant, OutData);
        end
        @(negedge clk);
        aclr = 1'b1;
        model_reset();
        lane_data[0] = 32'h300;
        lane_req     = 4'b0001;
        #1;
        n_cmp++;
        if (Grant !== 4'b0001 || FifoPush !== 1'b1) begin
            n_err++; $display("FAIL midrst_regrant: got grant=%b push=%b expected 0001/1", Grant, FifoPush);
        end
        model_step();
        @(posedge clk);
        #1;
        lanes_after_edge();
        @(negedge clk);
        n_cmp++;
        if (Count !== 5'd1) begin
            n_err++; $display("FAIL midrst_count: got %0d expected 1", Count);
        end
    endtask

    initial begin
        for (int l = 0; l < NR; l++) lane_data[l] = '0;
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_backpressure();
        test_wrap();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
